// File: rtl/randist_pkg.sv
// Shared constants and types for the randist scheduler slice.
package randist_pkg;

  localparam logic [63:0] FP64_ONE  = 64'h3ff0000000000000;
  localparam logic [63:0] FP64_ZERO = 64'h0000000000000000;

  localparam int NREQ_DEF = 4;
  localparam int TAGD_DEF = 32;
  localparam int IDW_DEF  = $clog2(NREQ_DEF);

  // Requester ID at the default requester count.
  typedef logic [IDW_DEF-1:0] req_id_t;

endpackage

// File: rtl/randist_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight sample.
// Pop on empty is dropped; push on full is prevented by the caller.
module randist_tag_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign dout   = mem[rptr];

  // Tag storage; contents need no reset, only the pointers do.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracks push/pop balance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/randist_sched.sv
// Round-robin scheduler sharing one randist pipeline among NREQ requesters.
// The pipeline cannot stall, so issue is throttled on tag FIFO occupancy.
module randist_sched
  import randist_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int TAGD = TAGD_DEF,
  parameter  int IDW  = $clog2(NREQ),
  localparam int CW   = $clog2(TAGD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_u1,
  input  logic [64*NREQ-1:0]   req_u2,
  output logic                 rd_push,
  output logic [63:0]          rd_u1,
  output logic [63:0]          rd_u2,
  input  logic                 rd_pushout,
  input  logic [63:0]          rd_z,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_z,
  output logic [IDW-1:0]       rsp_id,
  output logic [CW-1:0]        inflight,
  output logic                 busy,
  output logic                 err_orphan
);

  logic [IDW-1:0]  rr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            can_issue;
  logic            accept;
  logic            pop;
  logic            empty;
  logic [IDW-1:0]  tag;
  logic [NREQ-1:0] onehot;
  logic [CW-1:0]   count;

  // Same-cycle pop is not credited, so throttling is conservative.
  assign can_issue = (count < CW'(TAGD));
  assign req_ready = (can_issue & ~rst) ? grant : '0;
  assign accept    = |req_ready;
  assign pop       = rd_pushout & ~empty;
  assign inflight  = count;
  assign busy      = (count != '0);

  // Round-robin search: first valid requester at or after rr.
  always_comb begin
    logic           found;
    logic [IDW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    grant = '0;
    gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  // One-hot strobe for the returning tag.
  always_comb begin
    onehot      = '0;
    onehot[tag] = 1'b1;
  end

  // Issue stage: register the granted operands toward the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_push <= 1'b0;
      rd_u1   <= FP64_ZERO;
      rd_u2   <= FP64_ZERO;
      rr      <= '0;
    end else begin
      rd_push <= accept;
      if (accept) begin
        rd_u1 <= req_u1[int'(gidx)*64 +: 64];
        rd_u2 <= req_u2[int'(gidx)*64 +: 64];
        rr    <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  // Response stage: route each returning Z to the head tag's owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_z      <= FP64_ZERO;
      rsp_id     <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid  <= pop ? onehot : '0;
      if (pop) begin
        rsp_z  <= rd_z;
        rsp_id <= tag;
      end
      err_orphan <= err_orphan | (rd_pushout & empty);
    end
  end

  randist_tag_fifo #(.W(IDW), .DEPTH(TAGD)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (rd_pushout),
    .din   (gidx),
    .dout  (tag),
    .count (count),
    .empty (empty)
  );

endmodule

// File: doc/randist_sched.md
# randist_sched

Round-robin scheduler that shares one `randist` Box-Muller pipeline among NREQ independent requesters. It accepts (U1, U2) pairs over per-requester valid/ready handshakes and issues at most one pair per cycle into the pipeline. It records each issued requester ID in an in-order tag FIFO and, on each pipeline `pushout`, routes Z back to the originating requester. It sits between the requester ports and the `randist` instance; `randist` has no stall, so the scheduler enforces the in-flight limit.

## Interface
Parameters:
- NREQ, 4 — number of requesters (2..8).
- TAGD, 32 — tag FIFO depth; maximum issued-but-unreturned samples; power of two, ≥ randist latency + 2.
- IDW, $clog2(NREQ) — requester ID width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_u1  in  64*NREQ  U1 operands; slice i belongs to requester i.
- req_u2  in  64*NREQ  U2 operands; slice i belongs to requester i.
- rd_push  out  1  pushin to randist.
- rd_u1  out  64  U1 to randist.
- rd_u2  out  64  U2 to randist.
- rd_pushout  in  1  pushout from randist.
- rd_z  in  64  Z from randist.
- rsp_valid  out  NREQ  one-hot response strobe; no backpressure.
- rsp_z  out  64  response value.
- rsp_id  out  IDW  requester ID of the response.
- inflight  out  $clog2(TAGD+1)  current tag FIFO occupancy.
- busy  out  1  inflight != 0.
- err_orphan  out  1  sticky: pushout arrived with tag FIFO empty.

## Operation
- Eligibility: `can_issue = (inflight < TAGD)`. The pop in the same cycle is ignored, so throttling is conservative.
- Arbitration: combinational round-robin over req_valid, starting at pointer `rr`.
  - `req_ready[i] = can_issue & grant[i]`. Exactly one grant when any request is valid and `can_issue` holds.
  - `req_ready` does not depend on `rd_pushout`.
- Accept (req_valid[g] & req_ready[g]):
  - Register rd_u1/rd_u2 from slice g and set rd_push=1 next cycle.
  - Push g into the tag FIFO.
  - Update `rr ← (g+1) mod NREQ`.
- No accept: rd_push=0 next cycle. rd_u1/rd_u2 hold their last value. `rr` is unchanged.
- Return (rd_pushout=1):
  - Pop the head tag t.
  - Next cycle: rsp_valid = 1<<t, rsp_id=t, rsp_z=rd_z.
- Orphan (rd_pushout=1 with FIFO empty): no pop, no rsp_valid, err_orphan←1 until reset.
- Simultaneous push and pop: inflight is unchanged and both pointers advance.
- Pointers are log2(TAGD) bits and wrap naturally.
- rst must also drive the shared `randist` instance. Reset mid-operation discards all in-flight tags consistently with the pipeline flush.

## Timing
- Reset values: req_ready=0, rd_push=0, rd_u1=rd_u2=0, rsp_valid=0, rsp_z=0, rsp_id=0, inflight=0, busy=0, err_orphan=0, rr=0, FIFO pointers 0.
- Accept at edge k → rd_push high during cycle k+1 (one register stage).
- rd_pushout high at edge m → rsp_valid high during cycle m+1.
- Throughput is one sample per cycle while inflight < TAGD.
- Request-to-response latency = randist latency + 2 cycles.
- Order is strict FIFO: responses return in issue order, which is what ties tags to data.
- req_valid may drop without acceptance; no stickiness is required.

## Structure
- Package `randist_pkg`:
  - FP64_ONE = 64'h3ff0000000000000 and FP64_ZERO.
  - Default NREQ/TAGD.
  - Requester-ID typedef.
- Sub-module `randist_tag_fifo` (synchronous FIFO, width IDW, depth TAGD):
  - Ports: push/pop, data, count, empty.
  - Pop on empty is ignored.
  - Push when full cannot occur, because the scheduler prevents it.
- The top level holds the arbiter, the `rr` pointer, the issue registers, the response registers and err_orphan.

## Test plan
- Reset: assert rst mid-stream with 5 in flight → all outputs 0 within the same cycle, inflight=0; after release, a new request on requester 2 returns with rsp_id=2.
- Round-robin: all 4 requesters valid continuously with U1=0x3fe0000000000000 and distinct U2 → grants 0,1,2,3,0,…; rd_push every cycle; rsp_id sequence 0,1,2,3,…; each rsp_z matches a standalone randist golden value.
- Throttle: TAGD=4, model pushout held off → exactly 4 accepts, then req_ready=0 and inflight=4; one pushout → one further accept two cycles later.
- Simultaneous push/pop: steady issue with returns every cycle → inflight constant; no response lost or duplicated across 200 samples.
- Orphan: force rd_pushout=1 with an empty FIFO → err_orphan=1 and sticky, rsp_valid stays 0.
- Sparse traffic: only requester 3 valid every 5th cycle → rr stays consistent, latency is exactly randist latency + 2, rsp_valid=4'b1000.
